// File: rtl/matrix_collector.sv
// matrix_collector: assembles a SIZE x SIZE raster-tagged element stream into one flattened matrix with valid/ready output
module matrix_collector #(
   parameter int SIZE      = 3,
   parameter int WIDTH_BIT = 8,
   parameter int DATA_W    = 8
)(
   input  logic                        clock,
   input  logic                        nreset,
   input  logic                        clear,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_W-1:0]           in_data,
   input  logic [WIDTH_BIT-1:0]        in_i,
   input  logic [WIDTH_BIT-1:0]        in_j,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [SIZE*SIZE*DATA_W-1:0] out_matrix,
   output logic                        seq_err
);
   localparam logic [WIDTH_BIT-1:0] last_idx = WIDTH_BIT'(SIZE - 1);
   typedef enum logic {FILL, FULL} state_t;
   state_t                        state, state_nx;
   logic [WIDTH_BIT-1:0]          er, ec, er_nx, ec_nx;
   logic [SIZE*SIZE*DATA_W-1:0]   matrix_nx;
   logic                          accept, seq_err_nx;

   // next position, next state and tag check; the internal counters decide where data lands
   always_comb begin
      state_nx   = state;
      er_nx      = er;
      ec_nx      = ec;
      in_ready   = (state == FILL);
      out_valid  = (state == FULL);
      accept     = in_valid && in_ready;
      if (accept) begin
         ec_nx    = (ec == last_idx) ? '0 : ec + 1'b1;
         er_nx    = (ec == last_idx) ? ((er == last_idx) ? '0 : er + 1'b1) : er;
         state_nx = (er == last_idx && ec == last_idx) ? FULL : FILL;
      end else if (out_valid && out_ready) state_nx = FILL;
      seq_err_nx = seq_err | (accept && (in_i != er || in_j != ec));
   end

   // write the accepted element into its (er, ec) slot; other slots keep their old contents
   always_comb begin
      matrix_nx = out_matrix;
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++)
            if (accept && er == WIDTH_BIT'(r) && ec == WIDTH_BIT'(c))
               matrix_nx[(r*SIZE+c)*DATA_W +: DATA_W] = in_data;
   end

   // control state: async reset, then clear overrides any accept or handshake
   always_ff @(posedge clock or negedge nreset)
      if (!nreset) begin
         state   <= FILL;
         er      <= '0;
         ec      <= '0;
         seq_err <= 1'b0;
      end else if (clear) begin
         state   <= FILL;
         er      <= '0;
         ec      <= '0;
         seq_err <= 1'b0;
      end else begin
         state   <= state_nx;
         er      <= er_nx;
         ec      <= ec_nx;
         seq_err <= seq_err_nx;
      end

   // matrix storage: zeroed by reset or clear, otherwise updated element by element
   always_ff @(posedge clock or negedge nreset)
      if (!nreset) out_matrix <= '0;
      else if (clear) out_matrix <= '0;
      else out_matrix <= matrix_nx;
endmodule

// File: tb/tb_matrix_collector.sv
// tb_matrix_collector: directed stimulus with an element-count model checked every cycle plus literal expectations
module tb_matrix_collector;
   localparam int SIZE = 3, WIDTH_BIT = 8, DATA_W = 8, N = SIZE * SIZE;
   logic clock, nreset, clear, in_valid, in_ready, out_valid, out_ready, seq_err;
   logic [DATA_W-1:0] in_data;
   logic [WIDTH_BIT-1:0] in_i, in_j;
   logic [N*DATA_W-1:0] out_matrix, exp_mat;
   logic [DATA_W-1:0] m_mat [N];
   int m_k, n_cmp, n_bad;
   bit m_full, m_err;

   matrix_collector #(.SIZE(SIZE), .WIDTH_BIT(WIDTH_BIT), .DATA_W(DATA_W)) dut (
      .clock(clock), .nreset(nreset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_i(in_i), .in_j(in_j), .out_valid(out_valid), .out_ready(out_ready),
      .out_matrix(out_matrix), .seq_err(seq_err));

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_k = 0;
      m_full = 0;
      m_err = 0;
      for (int k = 0; k < N; k++) m_mat[k] = '0;
   endtask

   // model: a count of accepted elements; position (k/SIZE, k%SIZE) follows from the count
   initial begin
      model_reset();
      forever begin
         @(negedge clock);
         if (!nreset) model_reset();
         for (int k = 0; k < N; k++) exp_mat[k*DATA_W +: DATA_W] = m_mat[k];
         chk("m_in_ready", in_ready, !m_full);
         chk("m_out_valid", out_valid, m_full);
         chk("m_out_matrix", out_matrix, exp_mat);
         chk("m_seq_err", seq_err, m_err);
         if (nreset) begin
            if (clear) model_reset();
            else if (m_full) begin
               if (out_ready) m_full = 0;
            end else if (in_valid) begin
               if (in_i != m_k / SIZE || in_j != m_k % SIZE) m_err = 1;
               m_mat[m_k] = in_data;
               m_k++;
               if (m_k == N) begin
                  m_k = 0;
                  m_full = 1;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic send(input logic [7:0] d, input int i, input int j);
      in_valid = 1;
      in_data = d;
      in_i = i[7:0];
      in_j = j[7:0];
      tick();
   endtask

   task automatic idle(input int n);
      in_valid = 0;
      repeat (n) tick();
   endtask

   task automatic fill(input logic [7:0] base);
      for (int k = 0; k < N; k++) send(8'(base + k), k / SIZE, k % SIZE);
      in_valid = 0;
   endtask

   initial begin
      nreset = 0; clear = 0; in_valid = 0; in_data = 0; in_i = 0; in_j = 0; out_ready = 1;
      tick();
      tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_matrix", out_matrix, 0);
      nreset = 1;
      tick();
      // nominal
      fill(8'h01);
      chk("nom_valid", out_valid, 1);
      chk("nom_matrix", out_matrix, 72'h090807060504030201);
      chk("nom_err", seq_err, 0);
      chk("nom_ready_low", in_ready, 0);
      idle(1);
      chk("nom_ready_back", in_ready, 1);
      // backpressure
      out_ready = 0;
      fill(8'h01);
      in_data = 8'hAA;
      repeat (5) begin
         in_valid = ~in_valid;
         tick();
      end
      chk("bp_valid", out_valid, 1);
      chk("bp_matrix", out_matrix, 72'h090807060504030201);
      out_ready = 1;
      idle(1);
      chk("bp_fill", in_ready, 1);
      fill(8'h11);
      chk("bp_matrix2", out_matrix, 72'h191817161514131211);
      idle(1);
      // bubbles
      for (int k = 0; k < N; k++) begin
         send(8'(k + 1), k / SIZE, k % SIZE);
         if (k == 1 || k == 2 || k == 7) idle(2);
      end
      chk("bub_matrix", out_matrix, 72'h090807060504030201);
      chk("bub_valid", out_valid, 1);
      idle(1);
      // tag mismatch
      for (int k = 0; k < N; k++) begin
         send(8'(k + 1), k == 4 ? 1 : k / SIZE, k == 4 ? 2 : k % SIZE);
         if (k == 4) chk("tag_err_set", seq_err, 1);
      end
      chk("tag_matrix", out_matrix, 72'h090807060504030201);
      idle(1);
      chk("tag_err_sticky", seq_err, 1);
      clear = 1;
      tick();
      clear = 0;
      chk("clr_err", seq_err, 0);
      chk("clr_valid", out_valid, 0);
      chk("clr_matrix", out_matrix, 0);
      // clear mid-fill, then async reset mid-FULL
      for (int k = 0; k < 4; k++) send(8'(8'h50 + k), k / SIZE, k % SIZE);
      in_valid = 0;
      clear = 1;
      tick();
      clear = 0;
      out_ready = 0;
      fill(8'h21);
      chk("mid_matrix", out_matrix, 72'h292827262524232221);
      #1 nreset = 0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_ready", in_ready, 1);
      chk("arst_matrix", out_matrix, 0);
      tick();
      nreset = 1;
      tick();
      // clear with handshake, then input during handshake
      fill(8'h31);
      idle(1);
      out_ready = 1;
      clear = 1;
      tick();
      clear = 0;
      out_ready = 0;
      chk("sim_valid", out_valid, 0);
      chk("sim_matrix", out_matrix, 0);
      fill(8'h31);
      out_ready = 1;
      send(8'h77, 0, 0);
      out_ready = 0;
      send(8'h41, 0, 0);
      chk("hs_elem0", out_matrix[7:0], 8'h41);
      chk("hs_elem1", out_matrix[15:8], 8'h32);
      for (int k = 1; k < N; k++) send(8'(8'h41 + k), k / SIZE, k % SIZE);
      chk("hs_matrix", out_matrix, 72'h494847464544434241);
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/matrix_collector.md
Name: matrix_collector

Overview:
- Receiving end of the raster-index protocol: consumes a stream of matrix elements, each tagged with row/column indices (i, j) produced by the index generator.
- Assembles one SIZE x SIZE matrix in raster order, then presents it as a flattened word with a valid/ready handshake.
- Checks every incoming tag against its own expected position and flags mismatches (sticky error).
- Sits between the feature-map/kernel streaming logic and the convolution datapath.

Parameters:
- SIZE, 3, matrix dimension (rows = columns); SIZE >= 2.
- WIDTH_BIT, 8, width of the i/j index tags; 2^WIDTH_BIT > SIZE-1.
- DATA_W, 8, width of one matrix element.

Ports:
- clock  input  1  rising-edge clock
- nreset  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush, highest priority after reset
- in_valid  input  1  element present
- in_ready  output  1  collector can accept an element
- in_data  input  DATA_W  element value
- in_i  input  WIDTH_BIT  row tag of element
- in_j  input  WIDTH_BIT  column tag of element
- out_valid  output  1  complete matrix available
- out_ready  input  1  downstream accepts matrix
- out_matrix  output  SIZE*SIZE*DATA_W  flattened matrix; element (r,c) at bits [(r*SIZE+c)*DATA_W +: DATA_W]
- seq_err  output  1  sticky tag-mismatch flag

Behaviour:
- Reset: asynchronous on nreset low.
  - State FILL; expected row er = 0, expected column ec = 0.
  - out_matrix = 0, out_valid = 0, seq_err = 0, in_ready = 1.
- States: FILL, FULL.
  - in_ready = 1 in FILL, 0 in FULL (combinational from state).
  - out_valid = 1 in FULL, 0 in FILL (registered state).
- FILL accept: accept when in_valid && in_ready at the clock edge.
  - Store in_data at position (er, ec).
  - Advance ec = (ec < SIZE-1) ? ec+1 : 0.
  - Advance er = (ec == SIZE-1) ? er+1 : er.
  - When (er, ec) == (SIZE-1, SIZE-1) is accepted: er = ec = 0 and the next state is FULL.
  - out_valid rises the cycle after the last element is accepted (latency 1).
- No accept: in_valid low in FILL means no state change; bubbles are allowed anywhere in the stream.
- Tag check: on each accept, if in_i != er or in_j != ec, set seq_err = 1.
  - The element is still stored at (er, ec); the internal counters are authoritative.
  - seq_err stays set until reset or clear.
- FULL: out_matrix is held stable while out_valid = 1 && !out_ready.
  - On out_valid && out_ready, the next state is FILL.
  - out_matrix contents are retained (not zeroed) and are overwritten element by element during the next fill.
  - No input is accepted in the same cycle as the output handshake; the first element of the next matrix can be accepted the cycle after.
- clear (synchronous, when nreset is high): state = FILL, er = ec = 0, out_valid = 0, seq_err = 0, out_matrix = 0.
  - Any in-flight input or output handshake in that cycle is discarded.
  - clear overrides simultaneous accept or handshake.
- Reset mid-fill or mid-FULL: all partial data is discarded, and the block returns to the reset values above.
- Throughput: one matrix per SIZE*SIZE + 1 cycles minimum (SIZE*SIZE fill cycles plus 1 FULL cycle with out_ready held high).
- Width: in_i/in_j are compared zero-extended against er/ec; er/ec are WIDTH_BIT wide and never exceed SIZE-1.

Test Plan:
- Nominal fill: after reset, stream 9 elements with data 0x01..0x09 and correct tags (0,0)..(2,2), in_valid continuously high, out_ready=1.
  - Required: out_valid high exactly 1 cycle after the 9th accept; out_matrix = 0x090807060504030201; seq_err=0; in_ready low for 1 cycle.
- Backpressure: fill as above with out_ready=0 for 5 cycles.
  - Required: out_valid and out_matrix stay stable; in_ready=0 and in_valid pulses are ignored.
  - Then raise out_ready: FILL the next cycle; the next matrix with data 0x11..0x19 produces out_matrix = 0x191817161514131211.
- Bubbles: insert in_valid=0 gaps after elements 2, 3 and 8.
  - Required: same result as nominal; (er, ec) is unchanged during gaps.
- Tag mismatch: send the 5th element tagged (1,2) instead of (1,1).
  - Required: seq_err=1 from the next cycle and stays set; the element is stored at (1,1); out_matrix equals the nominal value.
  - Then pulse clear: seq_err=0, out_valid=0, out_matrix=0.
- clear/reset mid-operation: pulse clear after 4 accepted elements and then send 9 fresh elements; the output reflects only the fresh 9.
  - Repeat with nreset low for 1 cycle mid-FULL: out_valid=0 immediately (asynchronous), in_ready=1.
- Simultaneous events: in the FULL state assert out_ready and clear in the same cycle.
  - Required: no output transfer is counted; the block is in FILL with out_matrix=0.
  - Assert in_valid on the cycle of the output handshake: the element is not accepted; ec stays 0.
